instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 130 +++++++++++++
 tb/tb_instr_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited requests to instruction memory, a 2-entry
// in-flight PC FIFO, a 2-entry {instr, pc} buffer toward decode, and redirect handling.
module instr_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        instr_ready
);

  logic [63:0] fetchPc_q, fetchPc_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  discard_q, discard_d;
  logic [1:0]  bufCount_q, bufCount_d;
  logic [63:0] pcFifo_q [2];
  logic [63:0] pcFifo_d [2];
  logic [31:0] bufInstr_q [2];
  logic [31:0] bufInstr_d [2];
  logic [63:0] bufPc_q [2];
  logic [63:0] bufPc_d [2];

  logic       accept, response, consume, bufWrite;
  logic       pushIdx, writeIdx;
  logic [2:0] credit;
  logic       unusedTgtBits;

  assign unusedTgtBits = ^br_target[1:0];

  // Requests in flight plus buffered words may never exceed the buffer depth,
  // which is what makes buffer overflow impossible.
  assign credit    = {1'b0, outstanding_q} + {1'b0, bufCount_q};
  assign imem_req  = !reset && !br_taken && (credit < 3'(BUF_DEPTH));
  assign imem_addr = fetchPc_q;

  assign instr_valid = !reset && !br_taken && (bufCount_q != 2'd0);
  assign instr       = bufInstr_q[0];
  assign instr_pc    = bufPc_q[0];

  assign accept   = imem_req && imem_ready;
  assign response = imem_rvalid && (outstanding_q != 2'd0);
  assign consume  = instr_valid && instr_ready;
  assign bufWrite = response && (discard_q == 2'd0);

  // Both queues keep their oldest entry in slot 0 and shift on pop, so the
  // slot written on push is the occupancy left after any same-cycle pop.
  assign pushIdx  = outstanding_q[0] && !response;
  assign writeIdx = bufCount_q[0] && !consume;

  always_comb begin
    fetchPc_d     = fetchPc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    bufCount_d    = bufCount_q;
    pcFifo_d      = pcFifo_q;
    bufInstr_d    = bufInstr_q;
    bufPc_d       = bufPc_q;

    if (accept && !response) begin
      outstanding_d = outstanding_q + 2'd1;
    end else if (!accept && response) begin
      outstanding_d = outstanding_q - 2'd1;
    end

    if (response) begin
      pcFifo_d[0] = pcFifo_q[1];
      if (discard_q != 2'd0) begin
        discard_d = discard_q - 2'd1;
      end
    end
    if (accept) begin
      pcFifo_d[pushIdx] = fetchPc_q;
      fetchPc_d         = fetchPc_q + 64'd4;
    end

    if (consume) begin
      bufInstr_d[0] = bufInstr_q[1];
      bufPc_d[0]    = bufPc_q[1];
    end
    if (bufWrite) begin
      bufInstr_d[writeIdx] = imem_rdata;
      bufPc_d[writeIdx]    = pcFifo_q[0];
    end
    if (bufWrite && !consume) begin
      bufCount_d = bufCount_q + 2'd1;
    end else if (!bufWrite && consume) begin
      bufCount_d = bufCount_q - 2'd1;
    end

    // Every request still in flight after this edge belongs to the old path.
    if (br_taken) begin
      fetchPc_d  = {br_target[63:2], 2'b00};
      bufCount_d = 2'd0;
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q     <= RESET_PC;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
      bufCount_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pcFifo_q[i]   <= 64'd0;
        bufInstr_q[i] <= 32'd0;
        bufPc_q[i]    <= 64'd0;
      end
    end else begin
      fetchPc_q     <= fetchPc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      bufCount_q    <= bufCount_d;
      pcFifo_q      <= pcFifo_d;
      bufInstr_q    <= bufInstr_d;
      bufPc_q       <= bufPc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed per-cycle vector table, hand-written
// stall/redirect/wrap sequences, and a randomized run against a sequential-PC model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [63:0] br_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;

  instr_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycleNum = 0;
  int memLat = 1;
  bit accepted;
  bit consumed;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } memReq_t;
  memReq_t memQ[$];

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        brt;
    logic [63:0] tgt;
    logic        ird;
    logic        expReq;
    logic [63:0] expAddr;
    logic        expVld;
    logic [63:0] expPc;
  } vec_t;
  vec_t vecs[17];

  // Memory contents are derived from the address so any word identifies its PC.
  function automatic logic [31:0] wordOf(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one cycle's inputs plus the memory response at the falling edge, then
  // samples the handshakes once the combinational outputs have settled.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic brt,
                               input logic [63:0] tgt, input logic ird);
    @(negedge clk);
    reset       = rst;
    imem_ready  = rdy;
    br_taken    = brt;
    br_target   = tgt;
    instr_ready = ird;
    if (memQ.size() > 0 && memQ[0].due <= cycleNum) begin
      imem_rvalid = 1'b1;
      imem_rdata  = wordOf(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
    end
    #1;
    accepted = imem_req && imem_ready;
    consumed = instr_valid && instr_ready;
  endtask

  // Records the accepted request in the memory model and advances to the next edge.
  task automatic endCycle();
    if (accepted) memQ.push_back('{addr: imem_addr, due: cycleNum + memLat});
    if (reset) memQ.delete();
    checkOutput($sformatf("outstanding_le_2 cyc%0d", cycleNum), 64'(memQ.size() <= 2), 64'd1);
    @(posedge clk);
    cycleNum++;
  endtask

  task automatic doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
      endCycle();
    end
  endtask

  initial begin
    int accepts;
    int waitCnt;
    int delivered;
    logic [63:0] expPc;
    logic [63:0] prevPc;
    logic [63:0] tgt;
    logic        brt;
    bit          seen;

    reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    br_taken = 1'b0; br_target = 64'd0; instr_ready = 1'b0;

    // Directed table, 1-cycle memory: reset, streaming, stall, redirect to 0x103.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h0,   1'b0, 64'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h4,   1'b0, 64'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b0, 64'h8,   1'b1, 64'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h8,   1'b1, 64'h4};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'hC,   1'b0, 64'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b0, 64'h10,  1'b1, 64'h8};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h10,  1'b1, 64'hC};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h14,  1'b0, 64'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b0, 1'b0, 64'h18,  1'b1, 64'h10};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b0, 1'b0, 64'h18,  1'b1, 64'h10};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b0, 64'h18,  1'b1, 64'h10};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h18,  1'b1, 64'h14};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 64'h103, 1'b1, 1'b0, 64'h1C,  1'b0, 64'h0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h100, 1'b0, 64'h0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h104, 1'b0, 64'h0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b0, 64'h108, 1'b1, 64'h100};

    $display("[TB] directed vector table");
    memLat = 1;
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].brt, vecs[i].tgt, vecs[i].ird);
      checkOutput($sformatf("imem_req row%0d", i), 64'(imem_req), 64'(vecs[i].expReq));
      checkOutput($sformatf("imem_addr row%0d", i), imem_addr, vecs[i].expAddr);
      checkOutput($sformatf("instr_valid row%0d", i), 64'(instr_valid), 64'(vecs[i].expVld));
      if (vecs[i].rst) begin
        checkOutput($sformatf("instr_reset row%0d", i), 64'(instr), 64'd0);
        checkOutput($sformatf("instr_pc_reset row%0d", i), instr_pc, 64'd0);
      end
      if (vecs[i].expVld) begin
        checkOutput($sformatf("instr_pc row%0d", i), instr_pc, vecs[i].expPc);
        checkOutput($sformatf("instr row%0d", i), 64'(instr), 64'(wordOf(vecs[i].expPc)));
      end
      endCycle();
    end

    // Decode stalled for 10 cycles straight out of reset: only two fetches fit.
    $display("[TB] decode stall sequence");
    doReset();
    accepts = 0;
    prevPc = 64'd0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
      if (accepted) accepts++;
      if (instr_valid) begin
        if (seen) checkOutput($sformatf("stall_pc_stable cyc%0d", i), instr_pc, prevPc);
        prevPc = instr_pc;
        seen = 1'b1;
      end
      if (i == 9) begin
        checkOutput("stall_req_low", 64'(imem_req), 64'd0);
        checkOutput("stall_valid", 64'(instr_valid), 64'd1);
        checkOutput("stall_instr_pc", instr_pc, 64'd0);
        checkOutput("stall_instr", 64'(instr), 64'(wordOf(64'd0)));
      end
      endCycle();
    end
    checkOutput("stall_fetch_count", 64'(accepts), 64'd2);

    // Redirect with two requests in flight: both late responses must be dropped.
    $display("[TB] redirect with two outstanding");
    memLat = 3;
    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
      endCycle();
    end
    checkOutput("br_two_outstanding", 64'(memQ.size()), 64'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h100, 1'b1);
    checkOutput("br_cycle_req_low", 64'(imem_req), 64'd0);
    checkOutput("br_cycle_valid_low", 64'(instr_valid), 64'd0);
    endCycle();
    seen = 1'b0;
    waitCnt = 0;
    while (!seen && waitCnt < 20) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
      if (instr_valid) begin
        seen = 1'b1;
        checkOutput("br_first_pc", instr_pc, 64'h100);
        checkOutput("br_first_instr", 64'(instr), 64'(wordOf(64'h100)));
      end
      endCycle();
      waitCnt++;
    end
    checkOutput("br_valid_within_bound", 64'(seen), 64'd1);

    // Fetch address wrap at the top of the 64-bit space, with no bubble.
    $display("[TB] address wrap");
    memLat = 1;
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    endCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
    checkOutput("wrap_req_top", 64'(imem_req), 64'd1);
    checkOutput("wrap_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    endCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
    checkOutput("wrap_req_zero", 64'(imem_req), 64'd1);
    checkOutput("wrap_addr_zero", imem_addr, 64'd0);
    endCycle();

    // Randomized traffic checked against a sequential-PC-plus-redirect model.
    $display("[TB] random traffic");
    doReset();
    expPc = 64'd0;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      brt = ($urandom_range(0, 24) == 0);
      tgt = {$urandom, $urandom};
      memLat = $urandom_range(1, 5);
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), brt, tgt, 1'($urandom_range(0, 3) != 0));
      if (imem_req) checkOutput("rand_addr_aligned", 64'(imem_addr[1:0]), 64'd0);
      if (consumed) begin
        checkOutput($sformatf("rand_pc cyc%0d", cycleNum), instr_pc, expPc);
        checkOutput($sformatf("rand_instr cyc%0d", cycleNum), 64'(instr), 64'(wordOf(expPc)));
        expPc = expPc + 64'd4;
        delivered++;
      end
      if (brt) expPc = {tgt[63:2], 2'b00};
      endCycle();
    end
    checkOutput("rand_enough_delivered", 64'(delivered > 200), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
